// File: rtl/wb_stage_lsq.sv
// wb_stage_lsq: writeback stage with in-order load-response FIFO, load alignment, CSR/regfile commit and flushes.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage_lsq #(
  parameter int RESP_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mem_to_wb_valid,
  output logic             wb_allowin,
  input  logic [172:0]     mem_to_wb_bus,
  input  logic             resp_valid,
  input  logic [31:0]      resp_data,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             wb_load_wait,
  output logic             csr_re,
  output logic             csr_we,
  output logic [13:0]      csr_num,
  output logic [31:0]      csr_wmask,
  output logic [31:0]      csr_wvalue,
  input  logic [31:0]      csr_rvalue,
  output logic             ex_flush,
  output logic             ertn_flush,
  output logic [5:0]       wb_ecode,
  output logic [8:0]       wb_esubcode,
  output logic [31:0]      wb_ex_pc,
  output logic [31:0]      era_pc,
  output logic             resp_overflow,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_we,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata,
  output logic [CNT_W-1:0] retire_cnt
);
  localparam int AW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(RESP_DEPTH);
  logic          r_valid;
  logic [172:0]  r_bus;
  logic [31:0]   r_mem [RESP_DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0]   r_cnt;
  logic          r_ovf;
  logic [31:0]   w_pc, w_wdata, w_raw, w_ld_data;
  logic          w_rf_we, w_is_load, w_uns, w_csr_re, w_csr_we, w_ertn, w_ex;
  logic [1:0]    w_ld_size, w_ld_off;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic          w_nonempty, w_avail, w_ready_go, w_retire, w_flush, w_ld_ret, w_pop, w_push, w_drop;
  assign w_pc       = r_bus[172:141];
  assign w_rf_we    = r_bus[140];
  assign rf_waddr   = r_bus[139:135];
  assign w_wdata    = r_bus[134:103];
  assign w_is_load  = r_bus[102];
  assign w_ld_size  = r_bus[101:100];
  assign w_uns      = r_bus[99];
  assign w_ld_off   = r_bus[98:97];
  assign w_csr_re   = r_bus[96];
  assign w_csr_we   = r_bus[95];
  assign csr_num    = r_bus[94:81];
  assign csr_wmask  = r_bus[80:49];
  assign csr_wvalue = r_bus[48:17];
  assign w_ertn     = r_bus[16];
  assign w_ex       = r_bus[15];
  assign wb_ecode   = r_bus[14:9];
  assign wb_esubcode = r_bus[8:0];
  assign w_nonempty = r_cnt != '0;
  assign w_avail    = w_nonempty | resp_valid;
  assign w_ready_go = ~w_is_load | w_ex | w_avail;
  assign wb_allowin = ~r_valid | w_ready_go;
  assign w_retire   = r_valid & w_ready_go;
  assign w_flush    = w_retire & (w_ex | w_ertn);
  assign w_ld_ret   = w_retire & w_is_load & ~w_ex;
  assign w_pop      = w_ld_ret & w_nonempty;
  // a response consumed directly by a waiting load with an empty FIFO is never stored
  assign w_drop     = resp_valid & (r_cnt == FULL) & ~w_pop & ~w_flush;
  assign w_push     = resp_valid & ~w_flush & ~w_drop & ~(w_ld_ret & ~w_nonempty);
  assign w_raw      = w_nonempty ? r_mem[r_rd] : resp_data;
  assign w_byte     = w_raw[{w_ld_off, 3'b000} +: 8];
  assign w_half     = w_ld_off[1] ? w_raw[31:16] : w_raw[15:0];
  assign w_ld_data  = (w_ld_size == 2'd0) ? {{24{~w_uns & w_byte[7]}}, w_byte} :
                      (w_ld_size == 2'd1) ? {{16{~w_uns & w_half[15]}}, w_half} : w_raw;
  assign rf_wdata   = w_csr_re ? csr_rvalue : w_is_load ? w_ld_data : w_wdata;
  assign rf_we      = w_retire & w_rf_we & ~w_ex;
  assign csr_we     = w_retire & w_csr_we & ~w_ex;
  assign csr_re     = r_valid & w_csr_re;
  assign ex_flush   = w_retire & w_ex;
  assign ertn_flush = w_retire & w_ertn & ~w_ex;
  assign wb_ex_pc   = w_pc;
  assign era_pc     = csr_rvalue;
  assign wb_load_wait = r_valid & w_is_load & ~w_ex & ~w_avail;
  assign resp_overflow = r_ovf;
  assign debug_wb_pc       = w_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_bus   <= '0;
    end else begin
      if (wb_allowin) r_valid <= mem_to_wb_valid;
      if (mem_to_wb_valid & wb_allowin) r_bus <= mem_to_wb_bus;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= resp_data;
  end
  always_ff @(posedge clk) begin
    if (!resetn || w_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end
`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retire_cnt;
  always_ff @(posedge clk) begin
    if (!resetn) r_retire_cnt <= '0;
    else if (w_retire & ~w_ex) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
  end
  assign retire_cnt = r_retire_cnt;
`else
  assign retire_cnt = '0;
`endif
endmodule

// File: tb/tb_wb_stage_lsq.sv
// tb_wb_stage_lsq: directed scenarios plus a randomized run against a queue-based reference model.
module tb_wb_stage_lsq;
  localparam int DEPTH = 2;
  typedef struct packed {
    logic [31:0] pc; logic rf_we; logic [4:0] waddr; logic [31:0] wdata;
    logic is_load; logic [1:0] ld_size; logic ld_uns; logic [1:0] ld_off;
    logic csr_re; logic csr_we; logic [13:0] csr_num; logic [31:0] csr_wmask; logic [31:0] csr_wvalue;
    logic ertn; logic ex; logic [5:0] ecode; logic [8:0] esub;
  } bus_t;
  logic clk = 1'b0, resetn = 1'b0, mem_to_wb_valid = 1'b0, resp_valid = 1'b0;
  logic [31:0] resp_data = '0, csr_rvalue = '0;
  bus_t b = '0;
  logic wb_allowin, rf_we, wb_load_wait, csr_re, csr_we, ex_flush, ertn_flush, resp_overflow;
  logic [4:0] rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, csr_wmask, csr_wvalue, wb_ex_pc, era_pc, debug_wb_pc, debug_wb_rf_wdata, retire_cnt;
  logic [13:0] csr_num;
  logic [5:0] wb_ecode;
  logic [8:0] wb_esubcode;
  logic [3:0] debug_wb_rf_we;
  int n_chk = 0, n_fail = 0;
  wb_stage_lsq #(.RESP_DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .mem_to_wb_valid(mem_to_wb_valid), .wb_allowin(wb_allowin),
    .mem_to_wb_bus(b), .resp_valid(resp_valid), .resp_data(resp_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_load_wait(wb_load_wait),
    .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .csr_rvalue(csr_rvalue), .ex_flush(ex_flush), .ertn_flush(ertn_flush), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_ex_pc(wb_ex_pc), .era_pc(era_pc), .resp_overflow(resp_overflow),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata), .retire_cnt(retire_cnt)
  );
  always #5 clk = ~clk;
  task automatic cyc; @(posedge clk); #1; endtask
  function automatic bus_t alu(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
    bus_t x = '0;
    x.pc = pc; x.rf_we = 1'b1; x.waddr = wa; x.wdata = wd;
    return x;
  endfunction
  function automatic bus_t ld(input logic [31:0] pc, input logic [4:0] wa, input logic [1:0] sz,
                              input logic [1:0] off, input logic uns);
    bus_t x = '0;
    x.pc = pc; x.rf_we = 1'b1; x.waddr = wa; x.is_load = 1'b1; x.ld_size = sz; x.ld_off = off; x.ld_uns = uns;
    return x;
  endfunction
  // reference extension: shift the word down to the addressed lane, mask, then sign-fix arithmetically
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] sz, input logic [1:0] off, input logic uns);
    longint v;
    if (sz == 2'd0) begin
      v = longint'((w >> (off * 8)) % 256);
      if (!uns && v > 127) v -= 256;
    end else if (sz == 2'd1) begin
      v = longint'((w >> ((off / 2) * 16)) % 65536);
      if (!uns && v > 32767) v -= 65536;
    end else v = longint'(w);
    return v[31:0];
  endfunction
  task automatic test_reset;
    resetn = 1'b0; mem_to_wb_valid = 1'b0; resp_valid = 1'b0; b = '0;
    cyc; cyc; #1;
    n_chk++; if (wb_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin got %0b exp 1", wb_allowin); end
    n_chk++; if (rf_we !== 1'b0 || csr_we !== 1'b0 || csr_re !== 1'b0) begin n_fail++; $display("FAIL reset_we got rf %0b csrwe %0b csrre %0b exp 0", rf_we, csr_we, csr_re); end
    n_chk++; if (ex_flush !== 1'b0 || ertn_flush !== 1'b0 || wb_load_wait !== 1'b0) begin n_fail++; $display("FAIL reset_flags got ex %0b ertn %0b wait %0b exp 0", ex_flush, ertn_flush, wb_load_wait); end
    n_chk++; if (resp_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b exp 0", resp_overflow); end
    n_chk++; if (debug_wb_pc !== 32'h0 || debug_wb_rf_we !== 4'h0 || rf_wdata !== 32'h0 || wb_ex_pc !== 32'h0) begin n_fail++; $display("FAIL reset_data got pc %0h we %0h wd %0h expc %0h exp 0", debug_wb_pc, debug_wb_rf_we, rf_wdata, wb_ex_pc); end
    n_chk++; if (retire_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", retire_cnt); end
    resetn = 1'b1;
  endtask
  task automatic test_back_to_back;
    logic [31:0] exp_cnt;
    mem_to_wb_valid = 1'b1; b = alu(32'h1c001000, 5'd1, 32'd1);
    cyc;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) begin
        b = alu(32'h1c001000 + 32'(4 * (i + 1)), 5'(i + 2), 32'(3 * (i + 1) + 1));
        b.ex = (i + 1 == 4);
      end else mem_to_wb_valid = 1'b0;
      #1;
      n_chk++; if (rf_we !== (i != 4)) begin n_fail++; $display("FAIL b2b_rf_we[%0d] got %0b exp %0b", i, rf_we, i != 4); end
      n_chk++; if (ex_flush !== (i == 4)) begin n_fail++; $display("FAIL b2b_ex[%0d] got %0b exp %0b", i, ex_flush, i == 4); end
      if (i != 4) begin
        n_chk++; if (rf_wdata !== 32'(3 * i + 1)) begin n_fail++; $display("FAIL b2b_wdata[%0d] got %0h exp %0h", i, rf_wdata, 3 * i + 1); end
      end
      n_chk++; if (wb_allowin !== 1'b1) begin n_fail++; $display("FAIL b2b_allowin[%0d] got %0b exp 1", i, wb_allowin); end
      cyc;
    end
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = 32'd9;
`else
    exp_cnt = 32'd0;
`endif
    n_chk++; if (retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_retire_cnt got %0d exp %0d", retire_cnt, exp_cnt); end
  endtask
  task automatic test_alu;
    mem_to_wb_valid = 1'b1; b = alu(32'h1c000000, 5'd5, 32'h1234);
    cyc;
    mem_to_wb_valid = 1'b0; b = '0; #1;
    n_chk++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL alu_write got we %0b wa %0d wd %0h exp 1 5 1234", rf_we, rf_waddr, rf_wdata); end
    n_chk++; if (debug_wb_rf_we !== 4'hF || debug_wb_pc !== 32'h1c000000 || debug_wb_rf_wnum !== 5'd5 || debug_wb_rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL alu_debug got we %0h pc %0h wn %0d wd %0h", debug_wb_rf_we, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata); end
    cyc; #1;
    n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_idle got %0b exp 0", rf_we); end
  endtask
  task automatic test_load_early;
    resp_valid = 1'b1; resp_data = 32'h80FF7F01;
    cyc;
    resp_valid = 1'b0;
    cyc;
    mem_to_wb_valid = 1'b1; b = ld(32'h1c000004, 5'd6, 2'd0, 2'd1, 1'b0);
    cyc;
    mem_to_wb_valid = 1'b0; #1;
    n_chk++; if (rf_we !== 1'b1 || rf_wdata !== 32'h0000007F) begin n_fail++; $display("FAIL early_data got we %0b wd %0h exp 1 0000007f", rf_we, rf_wdata); end
    n_chk++; if (wb_load_wait !== 1'b0 || wb_allowin !== 1'b1) begin n_fail++; $display("FAIL early_flow got wait %0b allow %0b exp 0 1", wb_load_wait, wb_allowin); end
    cyc;
  endtask
  task automatic test_load_late;
    mem_to_wb_valid = 1'b1; b = ld(32'h1c000008, 5'd7, 2'd1, 2'd2, 1'b1);
    cyc;
    mem_to_wb_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (wb_load_wait !== 1'b1 || wb_allowin !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL late_wait[%0d] got wait %0b allow %0b we %0b exp 1 0 0", k, wb_load_wait, wb_allowin, rf_we); end
      cyc;
    end
    resp_valid = 1'b1; resp_data = 32'h80FF7F01; #1;
    n_chk++; if (rf_we !== 1'b1 || rf_wdata !== 32'h000080FF) begin n_fail++; $display("FAIL late_data got we %0b wd %0h exp 1 000080ff", rf_we, rf_wdata); end
    n_chk++; if (wb_load_wait !== 1'b0 || wb_allowin !== 1'b1) begin n_fail++; $display("FAIL late_flow got wait %0b allow %0b exp 0 1", wb_load_wait, wb_allowin); end
    cyc;
    resp_valid = 1'b0;
    mem_to_wb_valid = 1'b1; b = ld(32'h1c00000c, 5'd7, 2'd2, 2'd0, 1'b0);
    cyc;
    mem_to_wb_valid = 1'b0; #1;
    n_chk++; if (wb_load_wait !== 1'b1) begin n_fail++; $display("FAIL late_bypass_not_stored got wait %0b exp 1", wb_load_wait); end
    resp_valid = 1'b1; resp_data = 32'hA5A5_0F0F; #1;
    n_chk++; if (rf_wdata !== 32'hA5A50F0F) begin n_fail++; $display("FAIL late_word got %0h exp a5a50f0f", rf_wdata); end
    cyc;
    resp_valid = 1'b0;
  endtask
  task automatic test_exception;
    resp_valid = 1'b1; resp_data = 32'hDEADBEEF;
    cyc;
    resp_valid = 1'b0;
    mem_to_wb_valid = 1'b1; b = alu(32'h1c000010, 5'd3, 32'h55); b.ex = 1'b1; b.ecode = 6'h0B; b.esub = 9'h001;
    cyc;
    mem_to_wb_valid = 1'b0; resp_valid = 1'b1; resp_data = 32'hCAFEF00D; #1;
    n_chk++; if (ex_flush !== 1'b1 || rf_we !== 1'b0 || ertn_flush !== 1'b0) begin n_fail++; $display("FAIL ex_pulse got ex %0b we %0b ertn %0b exp 1 0 0", ex_flush, rf_we, ertn_flush); end
    n_chk++; if (wb_ex_pc !== 32'h1c000010 || wb_ecode !== 6'h0B || wb_esubcode !== 9'h001) begin n_fail++; $display("FAIL ex_info got pc %0h ec %0h esc %0h", wb_ex_pc, wb_ecode, wb_esubcode); end
    cyc;
    resp_valid = 1'b0; #1;
    n_chk++; if (ex_flush !== 1'b0) begin n_fail++; $display("FAIL ex_one_cycle got %0b exp 0", ex_flush); end
    mem_to_wb_valid = 1'b1; b = ld(32'h1c000014, 5'd8, 2'd2, 2'd0, 1'b0);
    cyc;
    mem_to_wb_valid = 1'b0; #1;
    n_chk++; if (wb_load_wait !== 1'b1) begin n_fail++; $display("FAIL ex_fifo_cleared got wait %0b exp 1", wb_load_wait); end
    resp_valid = 1'b1; resp_data = 32'h12345678; #1;
    n_chk++; if (rf_we !== 1'b1 || rf_wdata !== 32'h12345678) begin n_fail++; $display("FAIL ex_after_load got we %0b wd %0h exp 1 12345678", rf_we, rf_wdata); end
    cyc;
    resp_valid = 1'b0;
    mem_to_wb_valid = 1'b1; b = '0; b.pc = 32'h1c000018; b.ertn = 1'b1; csr_rvalue = 32'h1c0000ab;
    cyc;
    mem_to_wb_valid = 1'b0; #1;
    n_chk++; if (ertn_flush !== 1'b1 || ex_flush !== 1'b0 || era_pc !== 32'h1c0000ab) begin n_fail++; $display("FAIL ertn got ertn %0b ex %0b era %0h exp 1 0 1c0000ab", ertn_flush, ex_flush, era_pc); end
    cyc; #1;
    n_chk++; if (ertn_flush !== 1'b0) begin n_fail++; $display("FAIL ertn_one_cycle got %0b exp 0", ertn_flush); end
    csr_rvalue = '0;
  endtask
  task automatic test_overflow;
    for (int k = 0; k < 3; k++) begin
      resp_valid = 1'b1; resp_data = 32'h11110000 + 32'(k);
      cyc; #1;
      n_chk++; if (resp_overflow !== (k == 2)) begin n_fail++; $display("FAIL ovf_set[%0d] got %0b exp %0b", k, resp_overflow, k == 2); end
    end
    resp_valid = 1'b0;
    cyc; cyc; #1;
    n_chk++; if (resp_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b exp 1", resp_overflow); end
    mem_to_wb_valid = 1'b1; b = ld(32'h1c000020, 5'd9, 2'd2, 2'd0, 1'b0);
    cyc;
    b = ld(32'h1c000024, 5'd10, 2'd2, 2'd0, 1'b0); #1;
    n_chk++; if (rf_we !== 1'b1 || rf_wdata !== 32'h11110000) begin n_fail++; $display("FAIL ovf_first got we %0b wd %0h exp 1 11110000", rf_we, rf_wdata); end
    cyc;
    mem_to_wb_valid = 1'b0; #1;
    n_chk++; if (rf_we !== 1'b1 || rf_wdata !== 32'h11110001) begin n_fail++; $display("FAIL ovf_second got we %0b wd %0h exp 1 11110001", rf_we, rf_wdata); end
    mem_to_wb_valid = 1'b1; b = ld(32'h1c000028, 5'd11, 2'd2, 2'd0, 1'b0);
    cyc;
    mem_to_wb_valid = 1'b0; #1;
    n_chk++; if (wb_load_wait !== 1'b1 || resp_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_third_dropped got wait %0b ovf %0b exp 1 1", wb_load_wait, resp_overflow); end
    resetn = 1'b0;
    cyc; #1;
    n_chk++; if (wb_load_wait !== 1'b0 || resp_overflow !== 1'b0 || wb_allowin !== 1'b1) begin n_fail++; $display("FAIL midreset got wait %0b ovf %0b allow %0b exp 0 0 1", wb_load_wait, resp_overflow, wb_allowin); end
    resetn = 1'b1;
  endtask
  task automatic test_random;
    logic [31:0] q[$];
    bus_t cur, nb;
    logic [191:0] rnd;
    logic cv, mv, rv, avail, ready, ret, allow, pop, e_we;
    logic [31:0] rd, crv, e_wd, mcnt, e_cnt;
    resetn = 1'b0; mem_to_wb_valid = 1'b0; resp_valid = 1'b0;
    cyc; resetn = 1'b1;
    cv = 1'b0; cur = '0; mcnt = '0;
    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      nb = rnd[172:0];
      nb.ertn = 1'b0;
      nb.ex = ($urandom_range(0, 15) == 0);
      nb.csr_re = !nb.is_load && ($urandom_range(0, 7) == 0);
      mv = ($urandom_range(0, 3) != 0);
      rd = $urandom; crv = $urandom;
      pop = cv && cur.is_load && !cur.ex && q.size() > 0;
      rv = ($urandom_range(0, 2) == 0);
      if (q.size() == DEPTH && !pop) rv = 1'b0;
      mem_to_wb_valid = mv; b = nb; resp_valid = rv; resp_data = rd; csr_rvalue = crv;
      #1;
      avail = q.size() > 0 || rv;
      ready = !cur.is_load || cur.ex || avail;
      ret = cv && ready;
      allow = !cv || ready;
      e_we = ret && cur.rf_we && !cur.ex;
      n_chk++; if (wb_allowin !== allow) begin n_fail++; $display("FAIL rnd_allowin[%0d] got %0b exp %0b", i, wb_allowin, allow); end
      n_chk++; if (rf_we !== e_we) begin n_fail++; $display("FAIL rnd_rf_we[%0d] got %0b exp %0b", i, rf_we, e_we); end
      n_chk++; if (ex_flush !== (ret && cur.ex)) begin n_fail++; $display("FAIL rnd_ex[%0d] got %0b exp %0b", i, ex_flush, ret && cur.ex); end
      n_chk++; if (csr_we !== (ret && cur.csr_we && !cur.ex)) begin n_fail++; $display("FAIL rnd_csr_we[%0d] got %0b exp %0b", i, csr_we, ret && cur.csr_we && !cur.ex); end
      n_chk++; if (wb_load_wait !== (cv && cur.is_load && !cur.ex && !avail)) begin n_fail++; $display("FAIL rnd_wait[%0d] got %0b", i, wb_load_wait); end
      if (e_we) begin
        e_wd = cur.csr_re ? crv : cur.is_load ? ext(q.size() > 0 ? q[0] : rd, cur.ld_size, cur.ld_off, cur.ld_uns) : cur.wdata;
        n_chk++; if (rf_wdata !== e_wd) begin n_fail++; $display("FAIL rnd_wdata[%0d] got %0h exp %0h", i, rf_wdata, e_wd); end
      end
`ifdef WB_RETIRE_CNT_EN
      e_cnt = mcnt;
`else
      e_cnt = 32'd0;
`endif
      n_chk++; if (retire_cnt !== e_cnt || resp_overflow !== 1'b0) begin n_fail++; $display("FAIL rnd_cnt[%0d] got %0d ovf %0b exp %0d 0", i, retire_cnt, resp_overflow, e_cnt); end
      if (ret && cur.ex) q.delete();
      else if (ret && cur.is_load) begin
        if (q.size() > 0) begin
          void'(q.pop_front());
          if (rv) q.push_back(rd);
        end
      end else if (rv) q.push_back(rd);
      if (ret && !cur.ex) mcnt++;
      if (allow) begin
        cv = mv;
        if (mv) cur = nb;
      end
      @(posedge clk); #1;
    end
    mem_to_wb_valid = 1'b0; resp_valid = 1'b0;
  endtask
  initial begin
    test_reset;
    test_back_to_back;
    test_alu;
    test_load_early;
    test_load_late;
    test_exception;
    test_overflow;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
